pmem_arbiter: RTL and testbench

Two-port physical-memory arbiter that shares the single cacheline-adaptor / pmem port between the instruction cache (read-only) and the data cache (read and writeback). It sits between the two cache controllers' memory-side ports and the cacheline adaptor. It grants one 256-bit line transaction at a time, gives the D-cache priority, and uses a bounded starvation counter so the I-cache is never locked out.

---
 rtl/pmem_arbiter.sv | 99 +++++++++
 tb/tb_pmem_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmem_arbiter.sv
// Shares one cacheline-adaptor port between the I-cache and D-cache.
// D-cache has priority; a starvation counter bounds how long I waits.
module pmem_arbiter #(
    parameter int STARVE_LIMIT = 2,
    parameter int CNT_W        = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_pmem_read,
    input  logic [31:0]  i_pmem_address,
    output logic [255:0] i_pmem_rdata,
    output logic         i_pmem_resp,
    input  logic         d_pmem_read,
    input  logic         d_pmem_write,
    input  logic [31:0]  d_pmem_address,
    input  logic [255:0] d_pmem_wdata,
    output logic [255:0] d_pmem_rdata,
    output logic         d_pmem_resp,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [31:0]  pmem_address,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp,
    output logic [1:0]   owner
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT_I = 2'b01,
        GRANT_D = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    state_t           state, state_n;
    logic [CNT_W-1:0] starve_cnt, starve_cnt_n;
    logic             d_req;

    assign d_req = d_pmem_read | d_pmem_write;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
        end else begin
            state      <= state_n;
            starve_cnt <= starve_cnt_n;
        end
    end

    always_comb begin
        state_n      = state;
        starve_cnt_n = starve_cnt;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        i_pmem_resp  = 1'b0;
        d_pmem_resp  = 1'b0;
        unique case (state)
            IDLE: begin
                // I is forced ahead only once D has won LIMIT times in a row
                if (d_req && !(i_pmem_read && starve_cnt == LIMIT)) begin
                    state_n = GRANT_D;
                    if (!i_pmem_read)
                        starve_cnt_n = '0;
                    else if (starve_cnt != LIMIT)
                        starve_cnt_n = starve_cnt + 1'b1;
                end else if (i_pmem_read) begin
                    state_n      = GRANT_I;
                    starve_cnt_n = '0;
                end
            end
            GRANT_I: begin
                pmem_read    = i_pmem_read;
                pmem_address = i_pmem_address;
                i_pmem_resp  = pmem_resp;
                if (pmem_resp)
                    state_n = IDLE;
            end
            GRANT_D: begin
                pmem_write   = d_pmem_write;
                pmem_read    = d_pmem_read & ~d_pmem_write;
                pmem_address = d_pmem_address;
                pmem_wdata   = d_pmem_wdata;
                d_pmem_resp  = pmem_resp;
                if (pmem_resp)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;
    assign owner        = state;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Bench for pmem_arbiter: cache/adaptor stimulus checked every cycle
// against a transaction-level model of the arbitration rules.
module tb_pmem_arbiter;

    localparam int LIMIT = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_pmem_read;
    logic [31:0]  i_pmem_address;
    logic [255:0] i_pmem_rdata;
    logic         i_pmem_resp;
    logic         d_pmem_read;
    logic         d_pmem_write;
    logic [31:0]  d_pmem_address;
    logic [255:0] d_pmem_wdata;
    logic [255:0] d_pmem_rdata;
    logic         d_pmem_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic [1:0]   owner;

    pmem_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
        .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
        .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
        .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
        .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .owner(owner)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // model: who holds the port (0 none, 1 I, 2 D) and D-wins-while-I-waits
    int m_own = 0;
    int m_cnt = 0;
    int adapt = 0;
    bit i_busy, d_busy, i_done, d_done;
    int p_i, p_d, p_stray, lat_min, lat_max;
    bit use_pat;
    logic [255:0] pat;
    bit rec;
    logic [1:0] prev_own;
    logic [1:0] grants[$];

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [31:0] rand_line();
        logic [31:0] a;
        a = $urandom;
        a[4:0] = 5'd0;
        return a;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check();
        logic e_rd, e_wr;
        logic [31:0] e_ad;
        logic [255:0] e_wd;
        e_rd = 1'b0; e_wr = 1'b0; e_ad = '0; e_wd = '0;
        if (m_own == 1) begin
            e_rd = i_pmem_read;
            e_ad = i_pmem_address;
        end else if (m_own == 2) begin
            e_wr = d_pmem_write;
            e_rd = d_pmem_read && !d_pmem_write;
            e_ad = d_pmem_address;
            e_wd = d_pmem_wdata;
        end
        chk("owner", 256'(owner), 256'(m_own));
        chk("pmem_read", 256'(pmem_read), 256'(e_rd));
        chk("pmem_write", 256'(pmem_write), 256'(e_wr));
        chk("pmem_address", 256'(pmem_address), 256'(e_ad));
        chk("pmem_wdata", pmem_wdata, e_wd);
        chk("i_resp", 256'(i_pmem_resp), 256'(m_own == 1 && pmem_resp));
        chk("d_resp", 256'(d_pmem_resp), 256'(m_own == 2 && pmem_resp));
        chk("i_rdata", i_pmem_rdata, pmem_rdata);
        chk("d_rdata", d_pmem_rdata, pmem_rdata);
    endtask

    task automatic drive();
        int k;
        if (i_done) begin i_done = 0; i_busy = 0; i_pmem_read = 0; end
        if (d_done) begin
            d_done = 0; d_busy = 0; d_pmem_read = 0; d_pmem_write = 0;
        end
        if (!i_busy && $urandom_range(0, 99) < p_i) begin
            i_busy = 1; i_pmem_read = 1; i_pmem_address = rand_line();
        end
        if (!d_busy && $urandom_range(0, 99) < p_d) begin
            k = $urandom_range(0, 2);
            d_busy = 1;
            d_pmem_read = (k != 1);
            d_pmem_write = (k != 0);
            d_pmem_address = rand_line();
            d_pmem_wdata = rand256();
        end
        if (m_own != 0) pmem_resp = (adapt == 0);
        else pmem_resp = rst && ($urandom_range(0, 99) < p_stray);
        pmem_rdata = use_pat ? pat : rand256();
    endtask

    task automatic update();
        bit iq, dq;
        if (!rst) begin m_own = 0; m_cnt = 0; return; end
        if (m_own == 0) begin
            iq = i_pmem_read;
            dq = d_pmem_read || d_pmem_write;
            if (dq && !(iq && m_cnt == LIMIT)) begin
                m_own = 2;
                m_cnt = iq ? ((m_cnt < LIMIT) ? m_cnt + 1 : LIMIT) : 0;
            end else if (iq) begin
                m_own = 1;
                m_cnt = 0;
            end
            if (m_own != 0) adapt = $urandom_range(lat_min, lat_max);
        end else if (pmem_resp) begin
            if (m_own == 1) i_done = 1; else d_done = 1;
            m_own = 0;
        end else begin
            adapt--;
        end
    endtask

    task automatic step();
        drive();
        @(negedge clk);
        check();
        if (rec && prev_own == 2'b00 && owner != 2'b00) grants.push_back(owner);
        prev_own = owner;
        @(posedge clk);
        update();
        #1;
    endtask

    task automatic drain(input string tag);
        int n;
        p_i = 0; p_d = 0; p_stray = 0;
        n = 0;
        while ((i_busy || d_busy || m_own != 0) && n < 100) begin
            step();
            n++;
        end
        chk(tag, 256'(n < 100), 256'(1));
    endtask

    task automatic idle_inputs();
        i_pmem_read = 0; i_pmem_address = '0;
        d_pmem_read = 0; d_pmem_write = 0;
        d_pmem_address = '0; d_pmem_wdata = '0;
        pmem_resp = 0; pmem_rdata = '0;
        i_busy = 0; d_busy = 0; i_done = 0; d_done = 0;
    endtask

    initial begin
        logic [1:0] exp_order[6];
        logic [1:0] got;
        int n;
        exp_order = '{2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b01};
        rst = 0;
        idle_inputs();
        p_i = 0; p_d = 0; p_stray = 0; lat_min = 0; lat_max = 0;
        use_pat = 0; pat = '0; rec = 0; prev_own = '0;

        // reset held with both caches requesting, then release
        i_busy = 1; i_pmem_read = 1; i_pmem_address = 32'h40;
        d_busy = 1; d_pmem_read = 1; d_pmem_address = 32'h80;
        lat_min = 1; lat_max = 1;
        repeat (2) step();
        rst = 1;
        step();
        chk("grant_d_after_reset", 256'(owner), 256'(2'b10));
        drain("drain_reset");

        // single I fill, resp after 5 cycles with a fixed pattern
        i_busy = 1; i_pmem_read = 1; i_pmem_address = 32'h0000_0060;
        lat_min = 5; lat_max = 5;
        use_pat = 1; pat = {32{8'hA5}};
        step();
        chk("i_fill_addr", 256'(pmem_address), 256'(32'h60));
        drain("drain_i_fill");
        chk("i_fill_idle", 256'(owner), 256'(2'b00));
        use_pat = 0;

        // D writeback with read also asserted
        d_busy = 1; d_pmem_read = 1; d_pmem_write = 1;
        d_pmem_address = 32'h0000_1000;
        d_pmem_wdata = {8{32'h1234_5678}};
        lat_min = 2; lat_max = 2;
        step();
        chk("wb_write", 256'(pmem_write), 256'(1));
        chk("wb_read", 256'(pmem_read), 256'(0));
        chk("wb_wdata", pmem_wdata, {8{32'h1234_5678}});
        drain("drain_wb");

        // contention: both request continuously
        p_i = 100; p_d = 100; lat_min = 1; lat_max = 1;
        rec = 1;
        n = 0;
        while (grants.size() < 6 && n < 200) begin step(); n++; end
        rec = 0;
        for (int i = 0; i < 6; i++) begin
            got = (i < grants.size()) ? grants[i] : 2'b00;
            chk($sformatf("grant_order[%0d]", i), 256'(got), 256'(exp_order[i]));
        end
        drain("drain_contention");

        // reset in the middle of a D writeback
        d_busy = 1; d_pmem_write = 1; d_pmem_address = 32'h2000;
        d_pmem_wdata = rand256();
        lat_min = 20; lat_max = 20;
        repeat (2) step();
        chk("mid_owner_pre", 256'(owner), 256'(2'b10));
        rst = 0;
        m_own = 0; m_cnt = 0;
        #1;
        check();
        idle_inputs();
        i_busy = 1; i_pmem_read = 1; i_pmem_address = 32'h300;
        lat_min = 2; lat_max = 2;
        step();
        rst = 1;
        step();
        chk("i_after_reset", 256'(owner), 256'(2'b01));
        drain("drain_mid_reset");

        // stray responses while idle
        p_stray = 100;
        repeat (4) step();
        p_stray = 0;

        // randomized traffic
        p_i = 30; p_d = 40; p_stray = 20; lat_min = 0; lat_max = 4;
        repeat (2000) step();
        drain("drain_random");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
